// File: rtl/time_display_scan_pkg.sv
// Shared constants and segment lookup for the HH:MM:SS scanned display.
package time_disp_pkg;

  localparam logic [3:0] DIG_DASH  = 4'hE;
  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [5:0] HR_MAX    = 6'd23;
  localparam logic [5:0] MS_MAX    = 6'd59;

  typedef enum logic [2:0] {
    CONV_IDLE,
    CONV_HR,
    CONV_MIN,
    CONV_SEC,
    CONV_DONE
  } conv_state_t;

  // Active-high segments {g,f,e,d,c,b,a}; unused codes 10..13 stay dark.
  function automatic logic [6:0] seg_lookup(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:     s = 7'h3F;
      4'd1:     s = 7'h06;
      4'd2:     s = 7'h5B;
      4'd3:     s = 7'h4F;
      4'd4:     s = 7'h66;
      4'd5:     s = 7'h6D;
      4'd6:     s = 7'h7D;
      4'd7:     s = 7'h07;
      4'd8:     s = 7'h7F;
      4'd9:     s = 7'h6F;
      DIG_DASH: s = 7'h40;
      default:  s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/time_display_scan_bin2bcd.sv
// Sequential binary-to-two-digit converter: subtracts 10 per cycle.
// start loads value/max; done pulses for one cycle once tens/units are valid.
module bin2bcd_seq
  import time_disp_pkg::*;
(
  input  logic       clock,
  input  logic       clear_n,
  input  logic       start,
  input  logic [5:0] value,
  input  logic [5:0] max,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       done
);

  logic       busy;
  logic       over;
  logic [5:0] rem;
  logic [3:0] tcnt;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      busy  <= 1'b0;
      over  <= 1'b0;
      rem   <= '0;
      tcnt  <= '0;
      tens  <= '0;
      units <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        over <= (value > max);
        rem  <= value;
        tcnt <= '0;
      end else if (busy) begin
        // Out-of-range fields skip the loop and show dashes.
        if (over) begin
          tens  <= DIG_DASH;
          units <= DIG_DASH;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else if (rem >= 6'd10) begin
          rem  <= rem - 6'd10;
          tcnt <= tcnt + 4'd1;
        end else begin
          tens  <= tcnt;
          units <= rem[3:0];
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/time_display_scan.sv
// Snapshots sec/min/hr once per frame, converts to BCD and scans six
// seven-segment digits (HH MM SS); content changes only at frame start.
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int SEG_POL  = 0
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  input  logic       hold,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [5:0] dig_en,
  output logic       frame_tick
);

  localparam logic [15:0] PRE_LAST = 16'(SCAN_DIV - 1);
  localparam logic        POL      = (SEG_POL != 0);

  logic [15:0] prescaler;
  logic [2:0]  idx;
  logic        frame_start;

  logic [4:0]  snap_hr;
  logic [5:0]  snap_min;
  logic [5:0]  snap_sec;

  logic [3:0]  work   [6];
  logic [3:0]  shadow [6];
  logic [3:0]  buffer [6];
  logic [3:0]  cur_code;

  conv_state_t conv_state;
  logic        conv_start;
  logic [5:0]  conv_value;
  logic [5:0]  conv_max;
  logic [3:0]  conv_tens;
  logic [3:0]  conv_units;
  logic        conv_done;

  assign frame_start = (prescaler == '0) && (idx == '0);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
      idx       <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      snap_hr  <= '0;
      snap_min <= '0;
      snap_sec <= '0;
      for (int i = 0; i < 6; i++) buffer[i] <= DIG_BLANK;
    end else if (frame_start) begin
      for (int i = 0; i < 6; i++) buffer[i] <= shadow[i];
      if (!hold) begin
        snap_hr  <= hr;
        snap_min <= min;
        snap_sec <= sec;
      end
    end
  end

  always_comb begin
    conv_value = {1'b0, snap_hr};
    conv_max   = HR_MAX;
    if (conv_state == CONV_MIN) begin
      conv_value = snap_min;
      conv_max   = MS_MAX;
    end else if (conv_state == CONV_SEC) begin
      conv_value = snap_sec;
      conv_max   = MS_MAX;
    end
  end

  bin2bcd_seq u_conv (
    .clock  (clock),
    .clear_n(clear_n),
    .start  (conv_start),
    .value  (conv_value),
    .max    (conv_max),
    .tens   (conv_tens),
    .units  (conv_units),
    .done   (conv_done)
  );

  // Field sequencer; conv_start is issued on entry so the value mux
  // already selects the field being converted.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      conv_state <= CONV_IDLE;
      conv_start <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        work[i]   <= DIG_BLANK;
        shadow[i] <= DIG_BLANK;
      end
    end else begin
      conv_start <= 1'b0;
      case (conv_state)
        CONV_IDLE: begin
          if (frame_start) begin
            conv_state <= CONV_HR;
            conv_start <= 1'b1;
          end
        end
        CONV_HR: begin
          if (conv_done) begin
            work[0]    <= conv_tens;
            work[1]    <= conv_units;
            conv_state <= CONV_MIN;
            conv_start <= 1'b1;
          end
        end
        CONV_MIN: begin
          if (conv_done) begin
            work[2]    <= conv_tens;
            work[3]    <= conv_units;
            conv_state <= CONV_SEC;
            conv_start <= 1'b1;
          end
        end
        CONV_SEC: begin
          if (conv_done) begin
            work[4]    <= conv_tens;
            work[5]    <= conv_units;
            conv_state <= CONV_DONE;
          end
        end
        CONV_DONE: begin
          for (int i = 0; i < 6; i++) shadow[i] <= work[i];
          conv_state <= CONV_IDLE;
        end
        default: conv_state <= CONV_IDLE;
      endcase
    end
  end

  // At frame start the buffer is being reloaded, so read the incoming
  // shadow directly to keep digit 0 consistent with the rest of the frame.
  assign cur_code = frame_start ? shadow[idx] : buffer[idx];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      seg        <= {7{POL}};
      dig_en     <= {6{POL}};
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (blank) begin
        seg    <= {7{POL}};
        dig_en <= {6{POL}};
      end else begin
        seg    <= seg_lookup(cur_code) ^ {7{POL}};
        dig_en <= (6'b000001 << idx) ^ {6{POL}};
      end
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Bench for time_display_scan: frame-level reference model feeding an
// expected queue, compared each cycle against both polarity variants.
module tb_time_display_scan;

  localparam int SCAN_DIV = 8;
  localparam int FRAME    = SCAN_DIV * 6;

  logic       clock   = 1'b0;
  logic       clear_n = 1'b1;
  logic [5:0] sec     = '0;
  logic [5:0] min     = '0;
  logic [4:0] hr      = '0;
  logic       hold    = 1'b0;
  logic       blank   = 1'b0;

  logic [6:0] seg0, seg1;
  logic [5:0] dig0, dig1;
  logic       tick0, tick1;

  int n_checks = 0;
  int n_pass   = 0;

  // Entry layout: {frame_tick, dig_en[5:0], seg[6:0]} for SEG_POL=0.
  logic [13:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  time_display_scan #(.SCAN_DIV(SCAN_DIV), .SEG_POL(0)) dut0 (
    .clock(clock), .clear_n(clear_n), .sec(sec), .min(min), .hr(hr),
    .hold(hold), .blank(blank), .seg(seg0), .dig_en(dig0), .frame_tick(tick0)
  );

  time_display_scan #(.SCAN_DIV(SCAN_DIV), .SEG_POL(1)) dut1 (
    .clock(clock), .clear_n(clear_n), .sec(sec), .min(min), .hr(hr),
    .hold(hold), .blank(blank), .seg(seg1), .dig_en(dig1), .frame_tick(tick1)
  );

  // ---------------- reference model ----------------
  logic [6:0] lut [16];
  int         k;
  int         snap_h, snap_m, snap_s;
  logic [3:0] shown   [6];
  logic [3:0] pending [6];

  initial begin
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 7'h00};
  end

  function automatic void field_digits(input int v, input int vmax,
                                       output logic [3:0] t, output logic [3:0] u);
    if (v > vmax) begin
      t = 4'hE;
      u = 4'hE;
    end else begin
      t = 4'(v / 10);
      u = 4'(v % 10);
    end
  endfunction

  always @(posedge clock) begin
    if (!clear_n) begin
      k = 0;
      snap_h = 0; snap_m = 0; snap_s = 0;
      for (int i = 0; i < 6; i++) begin
        shown[i]   = 4'hF;
        pending[i] = 4'hF;
      end
    end else begin
      int pos, digit;
      logic [13:0] e;
      pos   = k % FRAME;
      digit = (k / SCAN_DIV) % 6;
      if (pos == 0) begin
        shown = pending;
        if (!hold) begin
          snap_h = int'(hr);
          snap_m = int'(min);
          snap_s = int'(sec);
        end
        field_digits(snap_h, 23, pending[0], pending[1]);
        field_digits(snap_m, 59, pending[2], pending[3]);
        field_digits(snap_s, 59, pending[4], pending[5]);
      end
      if (blank) e = {(pos == 0), 6'b0, 7'b0};
      else       e = {(pos == 0), 6'(1 << digit), lut[shown[digit]]};
      exp_q.push_back(e);
      k++;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, expv, $time);
  endtask

  logic [13:0] e_mon;

  always @(negedge clock) begin
    if (!clear_n) begin
      exp_q.delete();
      check("rst_tick0", {7'b0, tick0}, 8'h00);
      check("rst_dig0",  {2'b0, dig0},  8'h00);
      check("rst_seg0",  {1'b0, seg0},  8'h00);
      check("rst_tick1", {7'b0, tick1}, 8'h00);
      check("rst_dig1",  {2'b0, dig1},  8'h3F);
      check("rst_seg1",  {1'b0, seg1},  8'h7F);
    end else if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      check("tick0", {7'b0, tick0}, {7'b0, e_mon[13]});
      check("dig0",  {2'b0, dig0},  {2'b0, e_mon[12:7]});
      check("seg0",  {1'b0, seg0},  {1'b0, e_mon[6:0]});
      check("tick1", {7'b0, tick1}, {7'b0, e_mon[13]});
      check("dig1",  {2'b0, dig1},  {2'b0, ~e_mon[12:7]});
      check("seg1",  {1'b0, seg1},  {1'b0, ~e_mon[6:0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    @(negedge clock);
    #1;
    hr  = 5'(h);
    min = 6'(m);
    sec = 6'(s);
  endtask

  // Drops clear_n between edges so the asynchronous path is exercised.
  task automatic pulse_reset(input int n);
    @(posedge clock);
    #2 clear_n = 1'b0;
    repeat (n) @(negedge clock);
    #2 clear_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 clear_n = 1'b0;
    hr = 5'd23; min = 6'd59; sec = 6'd58;
    cycles(3);
    #2 clear_n = 1'b1;
    cycles(3 * FRAME);

    set_time(0, 0, 0);
    cycles(2 * FRAME + 5);
    set_time(0, 0, 9);
    cycles(2 * FRAME);

    set_time(24, 37, 60);
    cycles(2 * FRAME);

    set_time(12, 34, 56);
    cycles(2 * FRAME);
    hold = 1'b1;
    cycles(10);
    set_time(12, 35, 0);
    cycles(2 * FRAME);
    hold = 1'b0;
    cycles(2 * FRAME);

    cycles(13);
    blank = 1'b1;
    cycles(11);
    blank = 1'b0;
    cycles(FRAME);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0)
        set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      else
        set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      hold  = ($urandom_range(0, 4) == 0);
      blank = ($urandom_range(0, 5) == 0);
      cycles($urandom_range(5, 70));
    end
    hold  = 1'b0;
    blank = 1'b0;

    cycles(FRAME + 17);
    pulse_reset(3);
    cycles(3 * FRAME);
    cycles($urandom_range(3, 40));
    pulse_reset(2);
    set_time(7, 8, 9);
    cycles(3 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/time_display_scan.md
Name: time_display_scan

Overview:
- Reads the binary sec/min/hr outputs of the digital clock counter and turns them into a multiplexed 6-digit seven-segment display (HH MM SS).
- Once per display frame, snapshots the time, converts each field to two BCD digits with a sequential subtract-10 converter, and scans the digits one at a time.
- Sits between the clock counter and the board display pins.

Parameters:
- SCAN_DIV, 1000: clock cycles each digit stays enabled; legal range 8..65535.
- SEG_POL, 0: 0 = seg and dig_en active-high; 1 = both inverted (common-anode).

Ports:
- clock  in  1  system clock; all state on its rising edge
- clear_n  in  1  asynchronous, active-low reset
- sec  in  6  binary seconds, legal 0..59
- min  in  6  binary minutes, legal 0..59
- hr  in  5  binary hours, legal 0..23
- hold  in  1  1 = skip snapshot; the previous snapshot is reused
- blank  in  1  1 = all outputs inactive; scanning continues
- seg  out  7  segments {g,f,e,d,c,b,a}
- dig_en  out  6  one-hot digit enable; bit0 = hour tens ... bit5 = second units
- frame_tick  out  1  one-cycle pulse on the first cycle of each frame

Behaviour:
- Reset (clear_n=0, async): prescaler=0, idx=0, snapshot=0, converter idle, display buffer = all BLANK codes; seg=0, dig_en=0, frame_tick=0. Values are pre-SEG_POL.
- Counters:
  - prescaler counts 0..SCAN_DIV-1.
  - At wrap, idx advances 0..5 and wraps back to 0.
  - Frame start = the cycle in which prescaler==0 and idx==0. The first frame start is the first clock after clear_n deasserts.
- Frame start actions, all on the same edge:
  - commit the converted shadow digits into the display buffer;
  - if hold=0, snapshot sec/min/hr;
  - start the converter;
  - register frame_tick=1.
- Display latency: inputs sampled at frame N appear on the display from frame N+1. Display content never changes mid-frame (no tearing).
- Outputs are registered, one cycle after the counters:
  - dig_en = one-hot(idx);
  - seg = decode(buffer[idx]);
  - blank=1 forces seg=0 and dig_en=0 (before SEG_POL), taking effect the next cycle.
- Converter FSM states: IDLE -> HR -> MIN -> SEC -> DONE -> IDLE.
  - Each field state loads its value, then subtracts 10 per cycle while value >= 10, incrementing tens; the remainder is units.
  - Worst case is about 21 cycles, well inside one frame (>= 48 cycles).
  - Out-of-range field (hr > 23, or min/sec > 59): no subtraction; both digits = DASH.
  - DONE writes the shadow digits. Shadow changes only in DONE.
  - Frame start with the converter busy cannot occur at legal SCAN_DIV.
- Digit code 4 bits: 0..9 numeric, 0xE DASH, 0xF BLANK.
- Segment decode: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, DASH=40, BLANK=00.
- SEG_POL=1 inverts seg and dig_en at the output registers; the reset value then becomes all-ones.
- hold=1 during frame start: snapshot keeps its old value, the conversion reruns, and the display stays unchanged.
- Reset mid-frame: outputs go inactive immediately; restart exactly as after power-up. The first valid digits appear at the second frame start.

Decomposition:
- Package time_disp_pkg:
  - digit code constants DIG_DASH=4'hE, DIG_BLANK=4'hF;
  - the 16-entry segment lookup function;
  - field limits HR_MAX=23, MS_MAX=59.
- One sub-module, bin2bcd_seq:
  - inputs: start, value[5:0], max[5:0];
  - outputs: tens[3:0], units[3:0], done;
  - contains the subtract-10 loop.
- Top level: prescaler/idx counters, snapshot, field-sequencing FSM, buffers and output registers.

Test Plan (SCAN_DIV=8, SEG_POL=0, frame = 48 cycles):
- Release reset with hr=23, min=59, sec=58 -> frame 1 shows seg=00 on every digit; from frame 2, dig_en 000001..100000 shows 5B, 4F, 6D, 6F, 6D, 7F. frame_tick pulses every 48 cycles.
- hr=0, min=0, sec=0 -> all six digits 3F. Then sec=9 -> units digit 6F, tens digit 3F, exactly one frame after the change is sampled.
- sec=60, hr=24 -> hour digits 40 40, second digits 40 40, minute digits correct.
- hold=1 across a frame start while the inputs change 12:34:56 -> 12:35:00 -> display stays 06 5B 4F 66 6D 7D. Release hold -> new value appears after the next frame start plus one frame.
- blank=1 mid-frame -> seg=0 and dig_en=0 the next cycle. Deassert -> scanning resumes at the current idx with no frame realignment.
- clear_n pulsed low mid-frame (not on an edge) -> seg and dig_en drop to 0 asynchronously. Second frame after release shows the current input. Repeat with SEG_POL=1 and check inverted levels.
